bmd_256_latency_drain_ctrl: RTL and testbench

Sequences readout of the 48-bit timestamp FIFO, which holds one waiting_counter sample per CQ start-of-packet. Once the FIFO fills, or on a software start pulse, it drains the FIFO one entry at a time and hands each entry to the TX engine over a valid/ready handshake. Each handoff carries the raw timestamp and the inter-packet delta. It sits between the timestamp FIFO and the TX completion builder, and replaces the free-running full/empty read trigger.

---
 rtl/bmd_256_latency_drain_ctrl.sv | 144 ++++++++++++++
 tb/tb_bmd_256_latency_drain_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmd_256_latency_drain_ctrl.sv
// Drains the timestamp FIFO one entry at a time into the TX completion builder,
// pairing each raw timestamp with its delta from the previous entry of the drain.
module bmd_256_latency_drain_ctrl #(
    parameter int TS_W   = 48,
    parameter int CNT_W  = 14,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             latency_reset_signal,
    input  logic             start_req,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [TS_W-1:0]  fifo_dout,
    output logic             fifo_rd_en,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [TS_W-1:0]  tx_ts,
    output logic [TS_W-1:0]  tx_delta,
    output logic             tx_last,
    output logic             drain_busy,
    output logic             drain_done,
    output logic [CNT_W-1:0] drained_cnt,
    output logic [2:0]       state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    // tx handshake: an entry moves to TX on a cycle where tx_valid and tx_ready
    // are both high; while tx_valid is high without tx_ready, tx_ts, tx_delta
    // and tx_last hold their values.

    logic [2:0]       state_q, state_d;
    logic [1:0]       lat_q, lat_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  delta_q, delta_d;
    logic [TS_W-1:0]  prev_q, prev_d;
    logic             last_q, last_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        ts_d    = ts_q;
        delta_d = delta_q;
        prev_d  = prev_q;
        last_d  = last_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fifo_full || (start_req && !fifo_empty)) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
            end
            S_READ: begin
                if (!fifo_empty) begin
                    state_d = S_WAIT;
                    lat_d   = '0;
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    ts_d    = fifo_dout;
                    delta_d = first_q ? '0 : (fifo_dout - prev_q);
                    prev_d  = fifo_dout;
                    first_d = 1'b0;
                    // fifo_empty here already reflects the read just made
                    last_d  = fifo_empty;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = last_q ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (latency_reset_signal) begin
            state_d = S_IDLE;
            lat_d   = '0;
            ts_d    = '0;
            delta_d = '0;
            prev_d  = '0;
            last_d  = 1'b0;
            first_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            ts_q    <= '0;
            delta_q <= '0;
            prev_q  <= '0;
            last_q  <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            ts_q    <= ts_d;
            delta_q <= delta_d;
            prev_q  <= prev_d;
            last_q  <= last_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read strobe decoded from state so an async reset removes it immediately.
    assign fifo_rd_en  = (state_q == S_READ) && !fifo_empty;
    assign tx_valid    = (state_q == S_SEND);
    assign tx_last     = (state_q == S_SEND) && last_q;
    assign tx_ts       = ts_q;
    assign tx_delta    = delta_q;
    assign drain_busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign drain_done  = (state_q == S_DONE);
    assign drained_cnt = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_bmd_256_latency_drain_ctrl.sv
// Bench for bmd_256_latency_drain_ctrl: a queue-based FIFO model with one-cycle
// read latency feeds the DUT; handoffs are scored against hand-built expectations.
module tb_bmd_256_latency_drain_ctrl;
  localparam int TS_W  = 48;
  localparam int CNT_W = 14;
  localparam int DEPTH = 8192;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic             latency_reset_signal = 1'b0;
  logic             start_req = 1'b0;
  logic             fifo_full = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [TS_W-1:0]  fifo_dout = '0;
  logic             fifo_rd_en;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic [TS_W-1:0]  tx_ts;
  logic [TS_W-1:0]  tx_delta;
  logic             tx_last;
  logic             drain_busy;
  logic             drain_done;
  logic [CNT_W-1:0] drained_cnt;
  logic [2:0]       state_dbg;

  bmd_256_latency_drain_ctrl #(.TS_W(TS_W), .CNT_W(CNT_W), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .latency_reset_signal(latency_reset_signal),
    .start_req(start_req), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_ts(tx_ts), .tx_delta(tx_delta), .tx_last(tx_last),
    .drain_busy(drain_busy), .drain_done(drain_done), .drained_cnt(drained_cnt),
    .state_dbg(state_dbg)
  );

  // FIFO model: synchronous write, one-cycle read latency, flags after the edge
  logic            wr_en = 1'b0;
  logic [TS_W-1:0] wr_data = '0;
  logic            flush = 1'b0;
  logic [TS_W-1:0] fq[$];

  always @(posedge clk) begin
    if (flush) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_empty <= (fq.size() == 0);
    fifo_full  <= (fq.size() >= DEPTH);
  end

  // scoreboard
  logic [TS_W-1:0] exp_q[$];
  logic [TS_W-1:0] exp_dl_q[$];
  logic            exp_last_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int rd_empty_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (fifo_rd_en) rd_cnt++;
      if (fifo_rd_en && fifo_empty) rd_empty_err++;
      if (drain_done) done_cnt++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_handoff");
        end else begin
          chk("tx_ts", tx_ts, exp_q.pop_front());
          chk("tx_delta", tx_delta, exp_dl_q.pop_front());
          chk("tx_last", tx_last, exp_last_q.pop_front());
        end
        acc_cnt++;
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic write_entry(input logic [TS_W-1:0] v);
    wr_en = 1'b1;
    wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input logic [TS_W-1:0] ts, input logic [TS_W-1:0] dl, input logic last);
    exp_q.push_back(ts);
    exp_dl_q.push_back(dl);
    exp_last_q.push_back(last);
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == d0) fail_now({name, "_done_timeout"});
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k;
    k = 0;
    while (!tx_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!tx_valid) fail_now({name, "_valid_timeout"});
  endtask

  typedef struct {
    logic [TS_W-1:0] a;
    logic [TS_W-1:0] b;
    logic [TS_W-1:0] exp_delta;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int d0;
    int a0;
    int r0;
    int k;
    logic [TS_W-1:0] ts0;
    logic [TS_W-1:0] dl0;

    tbl[0] = '{a: 48'd10,             b: 48'd25,             exp_delta: 48'd15};
    tbl[1] = '{a: 48'hFFFF_FFFF_FFF0, b: 48'h0000_0000_0010, exp_delta: 48'h20};
    tbl[2] = '{a: 48'd1000,           b: 48'd999,            exp_delta: 48'hFFFF_FFFF_FFFF};
    tbl[3] = '{a: 48'd0,              b: 48'hFFFF_FFFF_FFFF, exp_delta: 48'hFFFF_FFFF_FFFF};
    tbl[4] = '{a: 48'h1234_5678_9ABC, b: 48'h1234_5678_9ABC, exp_delta: 48'd0};
    tbl[5] = '{a: 48'h8000_0000_0000, b: 48'd0,              exp_delta: 48'h8000_0000_0000};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", drain_busy, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_cnt", drained_cnt, 0);
    chk("rst_ts", tx_ts, 0);
    chk("rst_delta", tx_delta, 0);
    chk("rst_state", state_dbg, S_IDLE);

    // start_req on an empty FIFO is ignored
    r0 = rd_cnt;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("empty_start_rd", rd_cnt, r0);
    chk("empty_start_state", state_dbg, S_IDLE);
    chk("empty_start_busy", drain_busy, 0);

    // three entries 10/25/70
    push_exp(48'd10, 48'd0, 1'b0);
    push_exp(48'd25, 48'd15, 1'b0);
    push_exp(48'd70, 48'd45, 1'b1);
    write_entry(48'd10);
    write_entry(48'd25);
    write_entry(48'd70);
    d0 = done_cnt;
    pulse_start();
    wait_done(100, "three");
    chk("three_cnt", drained_cnt, 3);
    chk("three_done_pulses", done_cnt - d0, 1);
    chk("three_state", state_dbg, S_IDLE);

    // two-entry delta table
    for (int i = 0; i < 6; i++) begin
      push_exp(tbl[i].a, 48'd0, 1'b0);
      push_exp(tbl[i].b, tbl[i].exp_delta, 1'b1);
      write_entry(tbl[i].a);
      write_entry(tbl[i].b);
      d0 = done_cnt;
      pulse_start();
      wait_done(100, "tbl");
      chk("tbl_cnt", drained_cnt, 2);
      chk("tbl_done_pulses", done_cnt - d0, 1);
    end

    // backpressure: entry 2 stalled for 7 cycles
    push_exp(48'd1000, 48'd0, 1'b0);
    push_exp(48'd1003, 48'd3, 1'b0);
    push_exp(48'd1010, 48'd7, 1'b0);
    push_exp(48'd1020, 48'd10, 1'b0);
    push_exp(48'd1021, 48'd1, 1'b1);
    write_entry(48'd1000);
    write_entry(48'd1003);
    write_entry(48'd1010);
    write_entry(48'd1020);
    write_entry(48'd1021);
    tx_ready = 1'b0;
    pulse_start();
    for (int e = 0; e < 5; e++) begin
      wait_valid(50, "bp");
      if (e == 1) begin
        ts0 = tx_ts;
        dl0 = tx_delta;
        r0 = rd_cnt;
        repeat (7) begin
          @(negedge clk);
          chk("stall_valid", tx_valid, 1);
          chk("stall_ts", tx_ts, ts0);
          chk("stall_delta", tx_delta, dl0);
        end
        chk("stall_rd_en", rd_cnt, r0);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_done(50, "bp");
    chk("bp_cnt", drained_cnt, 5);

    // latency_reset_signal while entry 100 waits in SEND
    for (int i = 0; i < 120; i++) begin
      push_exp(48'd7 + 48'(2 * i), (i == 0) ? 48'd0 : 48'd2, 1'b0);
      write_entry(48'd7 + 48'(2 * i));
    end
    a0 = acc_cnt;
    pulse_start();
    k = 0;
    while (acc_cnt - a0 < 99 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    tx_ready = 1'b0;
    chk("abort_accepted", acc_cnt - a0, 99);
    wait_valid(20, "abort");
    chk("abort_entry100_ts", tx_ts, 48'd205);
    latency_reset_signal = 1'b1;
    @(negedge clk);
    latency_reset_signal = 1'b0;
    chk("abort_valid", tx_valid, 0);
    chk("abort_cnt", drained_cnt, 0);
    chk("abort_state", state_dbg, S_IDLE);
    chk("abort_ts", tx_ts, 0);
    chk("abort_delta", tx_delta, 0);
    chk("abort_busy", drain_busy, 0);
    exp_q.delete();
    exp_dl_q.delete();
    exp_last_q.delete();
    flush_fifo();
    tx_ready = 1'b1;

    // async reset while in READ
    write_entry(48'd5);
    write_entry(48'd6);
    start_req = 1'b1;
    @(posedge clk);
    #1;
    start_req = 1'b0;
    chk("ar_in_read", state_dbg, S_READ);
    chk("ar_rd_en_before", fifo_rd_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_rd_en_cleared", fifo_rd_en, 0);
    chk("ar_state", state_dbg, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    flush_fifo();

    // writes during a drain: 6 prefilled, then 10 more at one per 4 cycles
    for (int i = 0; i < 16; i++) begin
      push_exp(48'd1000 + 48'(10 * i), (i == 0) ? 48'd0 : 48'd10, i == 15);
    end
    for (int i = 0; i < 6; i++) write_entry(48'd1000 + 48'(10 * i));
    d0 = done_cnt;
    pulse_start();
    for (int i = 6; i < 16; i++) begin
      write_entry(48'd1000 + 48'(10 * i));
      repeat (3) @(negedge clk);
    end
    wait_done(200, "conc");
    chk("conc_cnt", drained_cnt, 16);
    chk("conc_done_pulses", done_cnt - d0, 1);

    // full FIFO of 8192 entries triggers the drain
    for (int i = 0; i < DEPTH; i++) begin
      push_exp(48'd100 + 48'(5 * i), (i == 0) ? 48'd0 : 48'd5, i == DEPTH - 1);
    end
    d0 = done_cnt;
    for (int i = 0; i < DEPTH; i++) write_entry(48'd100 + 48'(5 * i));
    wait_done(30000, "full");
    chk("full_cnt", drained_cnt, 8192);
    chk("full_done_pulses", done_cnt - d0, 1);

    chk("exp_left", exp_q.size(), 0);
    chk("rd_en_while_empty", rd_empty_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
